// File: rtl/insn_loader_if.sv
// insn_loader_if
//   Bundles the two buses of the program loader: the incoming instruction
//   stream (valid/ready with a last marker) and the write port into the
//   instruction memory bank.
//   Parameters: WIDTH  - instruction word width
//               ADDR_W - instruction memory address width
//   Modports:   master - host / stream source side (drives the stream,
//                        observes ready and the memory write port)
//               slave  - loader side (accepts the stream, drives ready and
//                        the memory write port)
interface insn_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/insn_loader.sv
// insn_loader
//   Program-load and run controller. Streams instruction words into
//   consecutive instruction memory addresses starting at 0, zero-fills the
//   rest of the bank, releases the core from reset for MAX_CYCLES cycles and
//   then holds it in reset again. The sequence can be re-run from HALT.
//
//   Ports:
//     clk, rst    - clock, synchronous active-high reset
//     start       - begin a load (only honoured in IDLE and HALT)
//     bus         - insn_loader_if.slave: stream in, memory write port out
//     core_rst    - processor reset, low only while running
//     running     - high in RUN
//     halted      - high in HALT
//     load_count  - stream words accepted in the current load
//     overflow    - sticky: program longer than DEPTH words
//     checksum    - (INSN_LOADER_CHECKSUM_EN only) XOR of accepted words
//
//   Optional feature macro: INSN_LOADER_CHECKSUM_EN
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LOAD   | accepting stream words, writing them from address 0 up
//   FILL   | writing zeros to the remaining addresses
//   RUN    | core out of reset, cycle counter running
//   HALT   | core back in reset, memory retained, waiting for start
module insn_loader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int MAX_CYCLES = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  insn_loader_if.slave      bus,
  output logic              core_rst,
  output logic              running,
  output logic              halted,
  output logic [ADDR_W:0]   load_count,
  output logic              overflow
`ifdef INSN_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]  checksum
`endif
);

  localparam int CYC_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RUN,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              overflow_q, overflow_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  logic in_ready;
  logic hs;
  logic start_ok;

  assign in_ready = (state_q == S_LOAD);
  assign hs       = bus.in_valid & in_ready;
  assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_HALT));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    cyc_d        = cyc_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_ok) begin
          state_d      = S_LOAD;
          ptr_d        = '0;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = ptr_q;
          mem_wdata_d  = bus.in_data;
          ptr_d        = ptr_q + ADDR_W'(1);
          load_count_d = load_count_q + (ADDR_W+1)'(1);
          // The last address ends the load whether or not the host marked
          // it; a missing last marker means the program did not fit.
          if (ptr_q == LAST_ADDR) begin
            state_d    = S_RUN;
            overflow_d = ~bus.in_last;
          end else if (bus.in_last) begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ptr_q;
        mem_wdata_d = '0;
        ptr_d       = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cyc_q == LAST_CYC) begin
          state_d = S_HALT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      load_count_q <= '0;
      overflow_q   <= 1'b0;
      cyc_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
      cyc_q        <= cyc_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

`ifdef INSN_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q, checksum_d;

  // Only stream handshakes contribute, so fill zeros and the RUN/HALT
  // phases leave the value untouched.
  always_comb begin
    checksum_d = checksum_q;
    if (start_ok) begin
      checksum_d = '0;
    end else if (hs) begin
      checksum_d = checksum_q ^ bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  // The last memory write is issued in the RUN entry cycle, so it lands on
  // the same edge at which the core first sees core_rst low.
  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst      = (state_q != S_RUN);
  assign running       = (state_q == S_RUN);
  assign halted        = (state_q == S_HALT);
  assign load_count    = load_count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_insn_loader.sv
// tb_insn_loader
//   Directed bench for insn_loader (DEPTH=16, MAX_CYCLES=50). Keeps a
//   shadow copy of instruction memory fed from the write port and compares
//   against hand-computed expectations.
module tb_insn_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic        core_rst;
  logic        running;
  logic        halted;
  logic [4:0]  load_count;
  logic        overflow;
`ifdef INSN_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_checks = 0;
  int n_errors = 0;

  insn_loader_if #(.WIDTH(32), .ADDR_W(4)) bus ();

  insn_loader #(
    .WIDTH(32), .DEPTH(16), .ADDR_W(4), .MAX_CYCLES(50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .core_rst   (core_rst),
    .running    (running),
    .halted     (halted),
    .load_count (load_count),
    .overflow   (overflow)
`ifdef INSN_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] tb_mem [16];
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the current sample until running rises (bounded).
  task automatic wait_run(output int n);
    n = 0;
    while (!running && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Called on the RUN entry sample; counts samples with core_rst low and
  // pulses start mid-run, which must be ignored.
  task automatic measure_run(output int n);
    n = (core_rst == 1'b0) ? 1 : 0;
    while (core_rst == 1'b0 && n < 200) begin
      start = (n == 10);
      tick();
      if (core_rst == 1'b0) n++;
    end
    start = 1'b0;
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 200) begin
      tick();
      n++;
    end
    chk("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    int n;
    int snap;
    int acc;
    logic rdy;
    logic [31:0] exp_w;

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) tick();

    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr",  {28'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_core_rst",  {31'd0, core_rst}, 32'd1);
    chk("rst_running",   {31'd0, running}, 32'd0);
    chk("rst_halted",    {31'd0, halted}, 32'd0);
    chk("rst_load_count", {27'd0, load_count}, 32'd0);
    chk("rst_overflow",  {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // 3-word program, then zero fill and a full run
    snap = wr_cnt;
    kick();
    chk("load_in_ready", {31'd0, bus.in_ready}, 32'd1);
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    push(32'h33, 1'b1);
    chk("t1_wr2_we",   {31'd0, bus.mem_we}, 32'd1);
    chk("t1_wr2_addr", {28'd0, bus.mem_addr}, 32'd2);
    chk("t1_wr2_data", bus.mem_wdata, 32'h33);
    chk("t1_fill_ready", {31'd0, bus.in_ready}, 32'd0);
    wait_run(n);
    chk("t1_fill_cycles", n, 32'd13);
    chk("t1_entry_addr", {28'd0, bus.mem_addr}, 32'd15);
    chk("t1_entry_we",   {31'd0, bus.mem_we}, 32'd1);
    chk("t1_load_count", {27'd0, load_count}, 32'd3);
    chk("t1_overflow",   {31'd0, overflow}, 32'd0);
`ifdef INSN_LOADER_CHECKSUM_EN
    chk("t1_checksum", checksum, 32'h0);
`endif
    measure_run(n);
    chk("t1_run_len",  n, 32'd50);
    chk("t1_halted",   {31'd0, halted}, 32'd1);
    chk("t1_core_rst", {31'd0, core_rst}, 32'd1);
    chk("t1_running",  {31'd0, running}, 32'd0);
    chk("t1_writes", wr_cnt - snap, 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_w = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : 32'h0;
      chk("t1_mem", tb_mem[i], exp_w);
    end

    // exactly 16 words, last on the 16th: straight to RUN
    snap = wr_cnt;
    kick();
    for (int i = 0; i < 16; i++) push(32'(i + 1), i == 15);
    chk("t2_no_fill",    {31'd0, running}, 32'd1);
    chk("t2_entry_addr", {28'd0, bus.mem_addr}, 32'd15);
    chk("t2_entry_data", bus.mem_wdata, 32'd16);
    chk("t2_overflow",   {31'd0, overflow}, 32'd0);
    chk("t2_load_count", {27'd0, load_count}, 32'd16);
    measure_run(n);
    chk("t2_run_len", n, 32'd50);
    chk("t2_writes", wr_cnt - snap, 32'd16);
    chk("t2_mem0",  tb_mem[0], 32'd1);
    chk("t2_mem15", tb_mem[15], 32'd16);

    // 17 words offered, no last marker
    snap = wr_cnt;
    kick();
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.in_data = 32'h100 + 32'(acc);
      rdy = bus.in_ready;
      tick();
      if (rdy) acc++;
    end
    chk("t3_accepted",   acc, 32'd16);
    chk("t3_in_ready",   {31'd0, bus.in_ready}, 32'd0);
    chk("t3_overflow",   {31'd0, overflow}, 32'd1);
    chk("t3_load_count", {27'd0, load_count}, 32'd16);
    wait_halt();
    bus.in_valid = 1'b0;
    chk("t3_writes", wr_cnt - snap, 32'd16);
    chk("t3_mem15",  tb_mem[15], 32'h10F);
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

    // reload from HALT with a single word
    snap = wr_cnt;
    kick();
    chk("t4_halted_clr", {31'd0, halted}, 32'd0);
    chk("t4_ovf_clr",    {31'd0, overflow}, 32'd0);
    push(32'hDEAD, 1'b1);
    chk("t4_load_count", {27'd0, load_count}, 32'd1);
    wait_run(n);
    chk("t4_fill_cycles", n, 32'd15);
`ifdef INSN_LOADER_CHECKSUM_EN
    chk("t4_checksum", checksum, 32'hDEAD);
`endif
    wait_halt();
    chk("t4_writes", wr_cnt - snap, 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp_w = (i == 0) ? 32'hDEAD : 32'h0;
      chk("t4_mem", tb_mem[i], exp_w);
    end
`ifdef INSN_LOADER_CHECKSUM_EN
    chk("t4_checksum_halt", checksum, 32'hDEAD);
`endif

    // reset while filling at ptr 7
    kick();
    push(32'hA5, 1'b1);
    repeat (6) tick();
    chk("t5_pre_addr", {28'd0, bus.mem_addr}, 32'd6);
    chk("t5_pre_we",   {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_mem_we",     {31'd0, bus.mem_we}, 32'd0);
    chk("t5_core_rst",   {31'd0, core_rst}, 32'd1);
    chk("t5_load_count", {27'd0, load_count}, 32'd0);
    chk("t5_in_ready",   {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    chk("t5_idle_ready",   {31'd0, bus.in_ready}, 32'd0);
    chk("t5_idle_running", {31'd0, running}, 32'd0);
    chk("t5_idle_halted",  {31'd0, halted}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
